// File: rtl/tug_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// tug_game_ctrl_if
//   Signal bundle between the tug-of-war game sequencer and its surroundings
//   (button pads, frame timing and the VGA pixel generator).
//   master : drives the buttons and frame_tick, consumes the display controls
//   slave  : the game sequencer itself
//   btn_l, btn_r : raw player buttons, active-high
//   frame_tick   : one-cycle pulse at the start of vertical blanking
//   leds_out     : rope position, one-hot, bit 6 = leftmost lamp
//   show_ready   : ready bars meaningful (not playing)
//   ready_l/r    : player armed flags as shown on screen
//   winner       : 00 none, 10 left won, 01 right won
// ---------------------------------------------------------------------------
interface tug_game_ctrl_if;
  logic       btn_l;
  logic       btn_r;
  logic       frame_tick;
  logic [6:0] leds_out;
  logic       show_ready;
  logic       ready_l;
  logic       ready_r;
  logic [1:0] winner;

  modport master (
    output btn_l, btn_r, frame_tick,
    input  leds_out, show_ready, ready_l, ready_r, winner
  );

  modport slave (
    input  btn_l, btn_r, frame_tick,
    output leds_out, show_ready, ready_l, ready_r, winner
  );
endinterface

// File: rtl/tug_game_ctrl.sv
// ---------------------------------------------------------------------------
// tug_game_ctrl
//   Game sequencer for the tug-of-war display. Synchronizes and debounces
//   the two player buttons, runs the ready / play / win state machine and
//   drives the rope lamp and ready-bar controls for the pixel generator.
//   Display-facing outputs are reloaded only on frame_tick so a frame never
//   shows a half-updated scene; winner is updated directly.
// Ports
//   clk25 : 25 MHz pixel clock
//   rst   : asynchronous, active-high reset
//   bus   : tug_game_ctrl_if.slave (buttons, frame_tick, display outputs)
// Parameters
//   DEBOUNCE_CYCLES : cycles a synced button level must persist to be accepted
//   FLASH_FRAMES    : frame_ticks per half-period of the winning lamp blink
// ---------------------------------------------------------------------------
module tug_game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FLASH_FRAMES    = 15
) (
  input  logic            clk25,
  input  logic            rst,
  tug_game_ctrl_if.slave  bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FL_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLASH_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2
  } state_t;

  // index 1 = left player, index 0 = right player
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {bus.btn_l, bus.btn_r};

  // -------------------------------------------------------------------------
  // Button conditioning: 2-flop synchronizer, then a counter that runs only
  // while the synced level disagrees with the accepted level. The accepted
  // level flips on the cycle the counter sits at its last value, and a press
  // is reported in that same cycle for a 0->1 flip.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;
      logic [DB_W-1:0] cnt_reg;

      always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          level_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = sync2_reg & ~level_reg & (cnt_reg == DB_LAST);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Game state
  // -------------------------------------------------------------------------
  state_t          state_reg, state_next;
  logic [2:0]      pos_reg, pos_next;
  logic            arm_l_reg, arm_l_next;
  logic            arm_r_reg, arm_r_next;
  logic [1:0]      winner_reg, winner_next;
  logic            blink_on_reg, blink_on_next;
  logic [FL_W-1:0] blink_cnt_reg, blink_cnt_next;

  // display shadow registers
  logic [6:0]      leds_reg, leds_next;
  logic            show_ready_reg, show_ready_next;
  logic            ready_l_reg, ready_l_next;
  logic            ready_r_reg, ready_r_next;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      pos_reg        <= 3'd3;
      arm_l_reg      <= 1'b0;
      arm_r_reg      <= 1'b0;
      winner_reg     <= 2'b00;
      blink_on_reg   <= 1'b1;
      blink_cnt_reg  <= '0;
      leds_reg       <= 7'b0001000;
      show_ready_reg <= 1'b1;
      ready_l_reg    <= 1'b0;
      ready_r_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pos_reg        <= pos_next;
      arm_l_reg      <= arm_l_next;
      arm_r_reg      <= arm_r_next;
      winner_reg     <= winner_next;
      blink_on_reg   <= blink_on_next;
      blink_cnt_reg  <= blink_cnt_next;
      leds_reg       <= leds_next;
      show_ready_reg <= show_ready_next;
      ready_l_reg    <= ready_l_next;
      ready_r_reg    <= ready_r_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pos_next        = pos_reg;
    arm_l_next      = arm_l_reg;
    arm_r_next      = arm_r_reg;
    winner_next     = winner_reg;
    blink_on_next   = blink_on_reg;
    blink_cnt_next  = blink_cnt_reg;
    leds_next       = leds_reg;
    show_ready_next = show_ready_reg;
    ready_l_next    = ready_l_reg;
    ready_r_next    = ready_r_reg;

    // Snapshot the current (pre-update) state on the tick; anything that
    // changes this cycle shows up at the following tick.
    if (bus.frame_tick) begin
      if (state_reg == WIN && !blink_on_reg) begin
        leds_next = 7'b0000000;
      end else begin
        leds_next = 7'b1000000 >> pos_reg;
      end
      show_ready_next = (state_reg != PLAY);
      ready_l_next    = arm_l_reg;
      ready_r_next    = arm_r_reg;
    end

    case (state_reg)
      IDLE, WIN: begin
        // blink phase advances on frame ticks only
        if (state_reg == WIN && bus.frame_tick) begin
          if (blink_cnt_reg == FL_LAST) begin
            blink_cnt_next = '0;
            blink_on_next  = ~blink_on_reg;
          end else begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
          end
        end
        // both flags already set last cycle: start a new round
        if (arm_l_reg && arm_r_reg) begin
          state_next  = PLAY;
          pos_next    = 3'd3;
          arm_l_next  = 1'b0;
          arm_r_next  = 1'b0;
          winner_next = 2'b00;
        end else begin
          arm_l_next = arm_l_reg | press[1];
          arm_r_next = arm_r_reg | press[0];
        end
      end

      PLAY: begin
        // simultaneous presses cancel out
        if (press[1] && !press[0]) begin
          pos_next = pos_reg - 3'd1;
          if (pos_reg == 3'd1) begin
            state_next     = WIN;
            winner_next    = 2'b10;
            blink_on_next  = 1'b1;
            blink_cnt_next = '0;
          end
        end else if (press[0] && !press[1]) begin
          pos_next = pos_reg + 3'd1;
          if (pos_reg == 3'd5) begin
            state_next     = WIN;
            winner_next    = 2'b01;
            blink_on_next  = 1'b1;
            blink_cnt_next = '0;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.leds_out   = leds_reg;
  assign bus.show_ready = show_ready_reg;
  assign bus.ready_l    = ready_l_reg;
  assign bus.ready_r    = ready_r_reg;
  assign bus.winner     = winner_reg;

endmodule
